// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_pc_next_calc.sv
// Next-PC selection for the fetch stage: sequential or branch target,
// aligned down to a word boundary, with a flag when alignment was needed.
module pc_next_calc
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] imm_op,
  input  logic                  pc_src,
  output logic [DATA_WIDTH-1:0] next_pc,
  output logic                  misaligned
);

  logic [DATA_WIDTH-1:0] raw_next;

  // Wrap-around past the top of the address space is silent by design.
  assign raw_next   = pc_src ? (pc + imm_op) : (pc + DATA_WIDTH'(INSTR_BYTES));
  assign next_pc    = {raw_next[DATA_WIDTH-1:2], 2'b00};
  assign misaligned = (raw_next[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding request to a variable-latency
// instruction memory, holds the word for decode until it retires.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCsrc,
  input  logic [DATA_WIDTH-1:0] ImmOp,
  input  logic                  stall,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] Instr,
  output logic                  Instr_valid,
  output logic [DATA_WIDTH-1:0] PC,
  output logic                  fetch_fault,
  output logic [31:0]           retire_count
);

  fetch_state_t          state;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic                  valid_q;
  logic                  fault_q;
  logic [31:0]           count_q;
  logic [DATA_WIDTH-1:0] next_pc;
  logic                  next_misaligned;

  pc_next_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pc_next_calc (
    .pc        (pc_q),
    .imm_op    (ImmOp),
    .pc_src    (PCsrc),
    .next_pc   (next_pc),
    .misaligned(next_misaligned)
  );

  // rvalid outside WAIT is dropped, which discards stale responses to
  // requests abandoned by a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= REQ;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      fault_q <= 1'b0;
      case (state)
        REQ: begin
          if (imem_ready) state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            pc_q    <= next_pc;
            fault_q <= next_misaligned;
            count_q <= count_q + 32'd1;
            valid_q <= 1'b0;
            state   <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

  assign imem_req     = (state == REQ);
  assign imem_addr    = pc_q;
  assign PC           = pc_q;
  assign Instr        = instr_q;
  assign Instr_valid  = valid_q;
  assign fetch_fault  = fault_q;
  assign retire_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; the bench plays the memory
// and decode sides cycle by cycle with hand-computed expectations.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        PCsrc;
  logic [31:0] ImmOp;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic        Instr_valid;
  logic [31:0] PC;
  logic        fetch_fault;
  logic [31:0] retire_count;

  int vectors;
  int miscompares;

  fetch_unit #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .PCsrc       (PCsrc),
    .ImmOp       (ImmOp),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .Instr       (Instr),
    .Instr_valid (Instr_valid),
    .PC          (PC),
    .fetch_fault (fetch_fault),
    .retire_count(retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full instruction from REQ through retire; entered and left in REQ.
  task automatic applyStimulus(input int readyWait, input int rvalidWait, input logic [31:0] data,
                               input int stallCycles, input logic pcsrc, input logic [31:0] imm,
                               input logic [31:0] expAddr, input logic [31:0] expNext,
                               input logic expFault, input logic [31:0] expCount);
    checkOutput("req_high", {31'd0, imem_req}, 32'd1);
    checkOutput("req_addr", imem_addr, expAddr);
    for (int i = 0; i < readyWait; i++) begin
      imem_ready  = 1'b0;
      imem_rvalid = (i == 1);
      imem_rdata  = 32'hDEAD_BEEF;
      stall       = 1'b1;
      tick();
      checkOutput("bp_req", {31'd0, imem_req}, 32'd1);
      checkOutput("bp_addr", imem_addr, expAddr);
      checkOutput("bp_valid", {31'd0, Instr_valid}, 32'd0);
    end
    imem_rvalid = 1'b0;
    imem_ready  = 1'b1;
    stall       = 1'b0;
    tick();
    imem_ready = 1'b0;
    checkOutput("wait_req", {31'd0, imem_req}, 32'd0);
    checkOutput("wait_valid", {31'd0, Instr_valid}, 32'd0);
    checkOutput("fault_pulse", {31'd0, fetch_fault}, 32'd0);
    for (int i = 0; i < rvalidWait; i++) begin
      imem_ready = 1'b1;
      tick();
      checkOutput("late_valid", {31'd0, Instr_valid}, 32'd0);
    end
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h1234_5678;
    checkOutput("hold_valid", {31'd0, Instr_valid}, 32'd1);
    checkOutput("hold_instr", Instr, data);
    checkOutput("hold_pc", PC, expAddr);
    for (int i = 0; i < stallCycles; i++) begin
      stall = 1'b1;
      PCsrc = (i % 2 == 0) ? ~pcsrc : pcsrc;
      ImmOp = 32'h0000_0100;
      tick();
      checkOutput("stall_instr", Instr, data);
      checkOutput("stall_pc", PC, expAddr);
      checkOutput("stall_count", retire_count, expCount - 32'd1);
      checkOutput("stall_valid", {31'd0, Instr_valid}, 32'd1);
    end
    stall = 1'b0;
    PCsrc = pcsrc;
    ImmOp = imm;
    tick();
    PCsrc = 1'b0;
    ImmOp = 32'd0;
    checkOutput("next_pc", PC, expNext);
    checkOutput("next_addr", imem_addr, expNext);
    checkOutput("fault", {31'd0, fetch_fault}, {31'd0, expFault});
    checkOutput("retire_count", retire_count, expCount);
    checkOutput("retire_valid", {31'd0, Instr_valid}, 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    PCsrc       = 1'b0;
    ImmOp       = 32'd0;
    stall       = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("rst_req", {31'd0, imem_req}, 32'd1);
    checkOutput("rst_pc", PC, 32'd0);
    checkOutput("rst_instr", Instr, 32'd0);
    checkOutput("rst_valid", {31'd0, Instr_valid}, 32'd0);
    checkOutput("rst_fault", {31'd0, fetch_fault}, 32'd0);
    checkOutput("rst_count", retire_count, 32'd0);

    // Reset release and straight-line run.
    applyStimulus(0, 0, 32'h0050_0093, 0, 1'b0, 32'd0, 32'h0, 32'h4, 1'b0, 32'd1);
    applyStimulus(0, 0, 32'h0010_0113, 0, 1'b0, 32'd0, 32'h4, 32'h8, 1'b0, 32'd2);
    applyStimulus(0, 0, 32'h0020_0193, 0, 1'b0, 32'd0, 32'h8, 32'hC, 1'b0, 32'd3);
    applyStimulus(0, 0, 32'h0030_0213, 0, 1'b0, 32'd0, 32'hC, 32'h10, 1'b0, 32'd4);

    // Branches: back to 8, backwards to 0, then a misaligned target.
    applyStimulus(0, 0, 32'hFE00_0CE3, 0, 1'b1, 32'hFFFF_FFF8, 32'h10, 32'h8, 1'b0, 32'd5);
    applyStimulus(0, 0, 32'hFE00_0CE3, 0, 1'b1, 32'hFFFF_FFF8, 32'h8, 32'h0, 1'b0, 32'd6);
    applyStimulus(0, 0, 32'h0000_0013, 0, 1'b0, 32'd0, 32'h0, 32'h4, 1'b0, 32'd7);
    applyStimulus(0, 0, 32'h0000_0013, 0, 1'b0, 32'd0, 32'h4, 32'h8, 1'b0, 32'd8);
    applyStimulus(0, 0, 32'h0000_0363, 0, 1'b1, 32'h0000_0006, 32'h8, 32'hC, 1'b1, 32'd9);

    // Long stall with PCsrc toggling, released with PCsrc low.
    applyStimulus(0, 0, 32'h0040_0293, 5, 1'b0, 32'h0000_0020, 32'hC, 32'h10, 1'b0, 32'd10);

    // Memory backpressure, spurious rvalid in REQ, slow response, branch to 0x40.
    applyStimulus(3, 3, 32'h0300_0063, 0, 1'b1, 32'h0000_0030, 32'h10, 32'h40, 1'b0, 32'd11);

    // Reset while a request to 0x40 is in flight, then a stale response.
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    checkOutput("inflight_req", {31'd0, imem_req}, 32'd0);
    checkOutput("inflight_pc", PC, 32'h40);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_pc", PC, 32'd0);
    checkOutput("arst_req", {31'd0, imem_req}, 32'd1);
    tick();
    rst         = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAAD_F00D;
    tick();
    imem_rvalid = 1'b0;
    checkOutput("stale_valid", {31'd0, Instr_valid}, 32'd0);
    checkOutput("stale_instr", Instr, 32'd0);
    checkOutput("stale_count", retire_count, 32'd0);

    // Fresh fetch from RESET_PC, then run off the top of the address space.
    applyStimulus(0, 0, 32'h0000_0013, 0, 1'b0, 32'd0, 32'h0, 32'h4, 1'b0, 32'd1);
    applyStimulus(0, 0, 32'hFE00_0CE3, 0, 1'b1, 32'hFFFF_FFF8, 32'h4, 32'hFFFF_FFFC, 1'b0, 32'd2);
    applyStimulus(0, 0, 32'h0000_0013, 0, 1'b0, 32'd0, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the control unit.
- Holds the program counter and issues one request at a time to a variable-latency instruction memory.
- Presents the returned word as `Instr`, with a valid flag, to decode/control.
- Takes the branch decision `PCsrc` and the sign-extended branch offset back from decode to select the next PC when the instruction retires.

Parameters:
- DATA_WIDTH, 32, instruction and PC width
- RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- PCsrc  input  1  branch taken; sampled only in the retire cycle
- ImmOp  input  DATA_WIDTH  sign-extended branch offset in bytes; sampled only in the retire cycle
- stall  input  1  downstream not ready; holds the current `Instr`
- imem_req  output  1  request valid to instruction memory
- imem_addr  output  DATA_WIDTH  request address, always equal to PC
- imem_ready  input  1  memory accepts the request this cycle
- imem_rvalid  input  1  read data valid
- imem_rdata  input  DATA_WIDTH  read data
- Instr  output  DATA_WIDTH  instruction to the control unit
- Instr_valid  output  1  `Instr` holds a fetched, unretired instruction
- PC  output  DATA_WIDTH  address of the current instruction
- fetch_fault  output  1  one-cycle pulse: computed next PC was misaligned
- retire_count  output  32  number of retired instructions, wraps

Behaviour:
- Reset (asynchronous assert; effective from the first clk edge after deassert):
  - state=REQ, PC=RESET_PC, Instr=0, Instr_valid=0, fetch_fault=0, retire_count=0.
  - imem_req is 1 in the first cycle after reset deassert.
- Retire cycle: the cycle with state=HOLD and stall=0.
- State REQ:
  - imem_req=1; imem_addr=PC, stable while imem_req is high.
  - On imem_ready=1: go to WAIT.
  - imem_rvalid in this state is ignored. This covers stale responses to requests abandoned by reset.
- State WAIT:
  - imem_req=0.
  - On imem_rvalid=1: Instr<=imem_rdata, Instr_valid<=1, go to HOLD.
  - Memory must not assert rvalid in the same cycle it accepts the request. The minimum response latency is 1 cycle after acceptance.
- State HOLD:
  - Instr_valid=1; Instr and PC are stable.
  - stall=1: remain in HOLD with no changes.
  - stall=0 (retire cycle):
    - raw_next = PCsrc ? PC+ImmOp : PC+4, computed modulo 2^DATA_WIDTH so wrap-around is silent.
    - PC<=raw_next with bits[1:0] forced to 0.
    - fetch_fault<=1 for one cycle if raw_next[1:0]!=0.
    - retire_count<=retire_count+1 (wraps 0xFFFF_FFFF -> 0).
    - Instr_valid<=0; go to REQ.
- PCsrc/ImmOp outside the retire cycle: ignored. Decode is combinational from `Instr`, so both are stable within HOLD.
- Throughput:
  - Best case is 1 instruction per 3 cycles: REQ accepted in 1 cycle, rvalid in the next, retire with stall=0.
  - Each cycle imem_ready is low, rvalid is late, or stall is high adds one cycle.
- Simultaneous events:
  - stall is ignored outside HOLD.
  - imem_ready is ignored outside REQ.
- Reset mid-operation: any state returns to REQ at RESET_PC and clears Instr_valid; the in-flight request is abandoned.
- fetch_fault is an informational flag only; fetch continues at the aligned address.

Decomposition:
- Package fetch_pkg:
  - enum fetch_state_t {REQ, WAIT, HOLD}
  - localparam INSTR_BYTES=4
  - default RESET_PC constant
- One natural sub-module, pc_next_calc: combinational; inputs PC, ImmOp, PCsrc; outputs aligned next PC and a misalign flag.

Test Plan:
1. Reset release, memory with 1-cycle ready and 1-cycle rvalid returning 32'h00500093, stall=0 -> imem_addr=0; Instr_valid rises 2 cycles after reset deassert; after retire PC=4, retire_count=1.
2. Straight-line run of 4 instructions, PCsrc=0 -> addresses requested 0,4,8,12; retires every 3 cycles; retire_count=4.
3. Branch at PC=8 with PCsrc=1, ImmOp=-8 (32'hFFFF_FFF8) -> next imem_addr=0; with ImmOp=6 -> imem_addr=12 (14 aligned down) and fetch_fault pulses for exactly 1 cycle.
4. Hold stall=1 for 5 cycles in HOLD; toggle PCsrc during the stall and drop it before release -> Instr, PC and retire_count unchanged during the stall; the next PC uses the PCsrc value present in the release cycle.
5. Memory backpressure: imem_ready low for 3 cycles, rvalid 4 cycles after acceptance -> imem_addr stable throughout; Instr_valid only after rvalid; a spurious rvalid during REQ is ignored.
6. Assert rst during WAIT at PC=0x40, then a stale rvalid in the first post-reset cycle -> PC=RESET_PC, Instr_valid=0, stale data not latched, fresh request to RESET_PC; retire_count=0; PC=0xFFFF_FFFC with PCsrc=0 wraps to 0.
